// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the instruction-memory loader.
//   Holds the loader state encoding, the default instruction width and the
//   derived bytes-per-word constant (BPW), plus a helper to compute the
//   bytes-per-word figure for any instruction width.
//   No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int INST_WIDTH_DEFAULT = 32;
    localparam int BPW                = INST_WIDTH_DEFAULT / 8;

    // CHK is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHK,
        DONE
    } loader_state_t;

    function automatic int bytes_per_word(input int inst_width);
        return inst_width / 8;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Groups the byte-stream handshake and the instruction-memory write port
//   of the loader.
//   Signals:
//     byte_valid / byte_data / byte_ready  : byte stream, valid/ready handshake
//     mem_wr_en / mem_wr_addr / mem_wr_data : instruction-memory write port
//   Modports:
//     slave  : the loader (consumes bytes, drives the memory write port)
//     master : the environment (stream source and memory sink)
// ---------------------------------------------------------------------------
interface imem_loader_if
    import riscv_pkg::*;
#(
    parameter int INST_WIDTH = 8 * BPW,
    parameter int MEM_SIZE   = 16
);
    localparam int AW = $clog2(MEM_SIZE);

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [INST_WIDTH-1:0] mem_wr_data;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Packs accepted bytes little-endian into an INST_WIDTH-bit word.
//   Ports:
//     clk, reset  : clock and synchronous active-high reset
//     clear       : drops any partial word and restarts at byte 0
//     accept      : byte_in is consumed this cycle
//     byte_in     : stream byte
//     word        : assembled word (complete the cycle after last_byte)
//     last_byte   : the byte consumed this cycle completes a word
// ---------------------------------------------------------------------------
module word_assembler
    import riscv_pkg::*;
#(
    parameter int INST_WIDTH = 8 * BPW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_in,
    output logic [INST_WIDTH-1:0] word,
    output logic                  last_byte
);

    localparam int WORD_BYTES = bytes_per_word(INST_WIDTH);
    localparam int CW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

    logic [CW-1:0] byte_cnt;

    assign last_byte = accept && (byte_cnt == LAST_IDX);

    // Bytes enter at the top and shift down, so after WORD_BYTES accepts the
    // first byte sits in bits [7:0] and the last in the top byte lane.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (accept) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
            word     <= INST_WIDTH'({byte_in, word} >> 8);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory path. Accepts a byte stream,
//   packs bytes little-endian into INST_WIDTH-bit words and writes them to
//   consecutive addresses starting at 0, holding the core in reset meanwhile.
//   Ports:
//     clk, reset  : clock and synchronous active-high reset
//     start       : begin a load (sampled only in IDLE)
//     num_words   : number of words to load, clamped to MEM_SIZE
//     bus         : byte stream + memory write port (imem_loader_if.slave)
//     core_hold   : hold the core in reset while not IDLE
//     busy        : not IDLE
//     done        : one-cycle completion pulse
//     err         : checksum mismatch, sticky until the next start
//   Optional feature: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
//   (8-bit sum of all data bytes) checked in a CHK state. Without it err
//   is tied to 0.
// ---------------------------------------------------------------------------
module imem_loader
    import riscv_pkg::*;
#(
    parameter int INST_WIDTH = 8 * BPW,
    parameter int MEM_SIZE   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(MEM_SIZE):0] num_words,
    imem_loader_if.slave             bus,
    output logic                     core_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [AW:0] MAX_WORDS = (AW + 1)'(MEM_SIZE);

    loader_state_t         state;
    loader_state_t         next_state;
    logic [AW-1:0]         index;
    logic [AW:0]           count;
    logic [AW:0]           start_words;
    logic                  data_accept;
    logic                  last_byte;
    logic                  last_word;
    logic [INST_WIDTH-1:0] word;

    assign start_words = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign last_word   = (({1'b0, index}) + (AW + 1)'(1)) == count;
    assign data_accept = (state == RECV) && bus.byte_valid;

    // Clearing in IDLE guarantees a word cut short by reset or a previous
    // load never leaks bytes into the next load.
    word_assembler #(
        .INST_WIDTH (INST_WIDTH)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .accept    (data_accept),
        .byte_in   (bus.byte_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Everything except IDLE holds the core; the write port is only non-zero
    // during the single WRITE cycle.
    always_comb begin
        next_state      = state;
        bus.byte_ready  = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        busy            = 1'b1;
        core_hold       = 1'b1;
        done            = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                core_hold = 1'b0;
                if (start) begin
                    next_state = (start_words == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                bus.byte_ready = 1'b1;
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = index;
                bus.mem_wr_data = word;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    next_state = DONE;
                end
            end
`endif
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word count is latched once at start; index advances after each
    // non-final write.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
            count <= '0;
        end else if (state == IDLE && start) begin
            index <= '0;
            count <= start_words;
        end else if (state == WRITE && !last_word) begin
            index <= index + AW'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;

    // Running mod-256 sum of data bytes; the trailing byte accepted in CHK is
    // compared against it and a mismatch latches err until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            if (data_accept) begin
                sum <= sum + bus.byte_data;
            end
            if (state == CHK && bus.byte_valid && bus.byte_data != sum) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader (MEM_SIZE=16, INST_WIDTH=32).
//   A negedge monitor logs every memory write and accepted byte; loads are
//   checked against words packed from the bytes the bench itself sent.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int INST_WIDTH = 32;
    localparam int MEM_SIZE   = 16;
    localparam int AW         = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader_if #(.INST_WIDTH(INST_WIDTH), .MEM_SIZE(MEM_SIZE)) bus ();

    imem_loader #(
        .INST_WIDTH (INST_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .bus       (bus),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] basic_bytes [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA1, 8'h00};

    // Monitor state: everything observed on the DUT outputs between edges.
    int          wlog_addr [$];
    logic [31:0] wlog_data [$];
    logic [7:0]  acc_q     [$];
    int          done_cnt  = 0;
    int          proto_err = 0;
    int          hs_since  = 0;
    bit          prev_done = 1'b0;

    // Watches the bus at negedge: logs writes, flags non-zero address/data
    // without a strobe, writes that do not follow exactly one word of
    // handshakes, and core_hold/busy still high the cycle after done.
    always @(negedge clk) begin
        if (reset) begin
            hs_since  = 0;
            prev_done = 1'b0;
        end else begin
            if (start && !busy) hs_since = 0;
            if (bus.mem_wr_en) begin
                wlog_addr.push_back(int'(bus.mem_wr_addr));
                wlog_data.push_back(bus.mem_wr_data);
                if (hs_since != 4) proto_err++;
                hs_since = 0;
            end else if (bus.mem_wr_addr != '0 || bus.mem_wr_data != '0) begin
                proto_err++;
            end
            if (prev_done && (core_hold || busy)) proto_err++;
            if (done) done_cnt++;
            prev_done = done;
            if (bus.byte_valid && bus.byte_ready) begin
                acc_q.push_back(bus.byte_data);
                hs_since++;
            end
        end
    end

    typedef struct {
        int n;
        int gap;
        int exp_writes;
        bit bad_sum;
    } load_vec_t;

    load_vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pack_word(input logic [7:0] bytes [$], input int w);
        logic [31:0] v = '0;
        for (int k = 0; k < 4; k++) v = v | (32'(bytes[4*w + k]) << (8*k));
        return v;
    endfunction

    task automatic start_load(input int n);
        start     = 1'b1;
        num_words = (AW + 1)'(n);
        step();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, output bit ok);
        ok = 1'b0;
        for (int s = 0; s < stall; s++) begin
            bus.byte_valid = 1'b0;
            step();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.byte_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        if (!ok) checkOutput("byte_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                checkOutput({tag, "_hold_during_done"}, 64'({core_hold, busy}), 64'b11);
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            @(negedge clk);
            checkOutput({tag, "_hold_drop"}, 64'({core_hold, busy, done}), 64'b000);
        end
    endtask

    // Full load: sends exp_writes words of bytes (plus the checksum byte when
    // enabled), then checks writes, accepted bytes, done and err.
    task automatic run_load(input int n, input int exp_writes, input int gap, input bit basic,
                            input bit bad_sum, input bit inject_start, input string tag);
        logic [7:0] sent [$];
        logic [7:0] sum = '0;
        int  w0, a0, d0, p0, f0, mism;
        bit  ok = 1'b1;
        for (int i = 0; i < 4*exp_writes; i++) begin
            sent.push_back(basic ? basic_bytes[i % 8] : 8'($urandom_range(0, 255)));
            sum = sum + sent[i];
        end
        w0 = wlog_data.size(); a0 = acc_q.size(); d0 = done_cnt; p0 = proto_err; f0 = failures;
        start_load(n);
        for (int i = 0; i < sent.size(); i++) begin
            if (inject_start && i == 2) begin
                start     = 1'b1;
                num_words = 5'd1;
            end
            send_byte(sent[i], (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 3)), ok);
            start = 1'b0;
            if (!ok) break;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ok) begin
            sent.push_back(bad_sum ? sum + 8'd1 : sum);
            send_byte(sent[sent.size()-1], 0, ok);
        end
`endif
        bus.byte_valid = 1'b0;
        wait_done(tag);
        step();
        checkOutput({tag, "_write_count"}, 64'(wlog_data.size() - w0), 64'(exp_writes));
        for (int i = 0; i < exp_writes && (w0 + i) < wlog_data.size(); i++) begin
            checkOutput({tag, "_addr"}, 64'(wlog_addr[w0+i]), 64'(i));
            checkOutput({tag, "_data"}, 64'(wlog_data[w0+i]), 64'(pack_word(sent, i)));
        end
        mism = 0;
        for (int i = 0; i < sent.size() && (a0 + i) < acc_q.size(); i++)
            if (acc_q[a0+i] !== sent[i]) mism++;
        checkOutput({tag, "_accepted_count"}, 64'(acc_q.size() - a0), 64'(sent.size()));
        checkOutput({tag, "_accepted_bytes"}, 64'(mism), 64'd0);
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        checkOutput({tag, "_protocol"}, 64'(proto_err - p0), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checkOutput({tag, "_err"}, 64'(err), 64'(bad_sum));
`else
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
`endif
        if (failures != f0) begin
            reset = 1'b1;
            step();
            step();
            reset = 1'b0;
            step();
        end
    endtask

    task automatic applyStimulus(input load_vec_t v, input int idx);
        run_load(v.n, v.exp_writes, v.gap, 1'b0, v.bad_sum, 1'b0, $sformatf("vec%0d", idx));
    endtask

    initial begin
        int  w0;
        bit  ok;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        vecs[0] = '{n: 1,  gap: 0, exp_writes: 1,  bad_sum: 1'b0};
        vecs[1] = '{n: 3,  gap: 1, exp_writes: 3,  bad_sum: 1'b0};
        vecs[2] = '{n: 20, gap: 2, exp_writes: 16, bad_sum: 1'b0};
        vecs[3] = '{n: 16, gap: 0, exp_writes: 16, bad_sum: 1'b0};
        vecs[4] = '{n: 17, gap: 1, exp_writes: 16, bad_sum: 1'b0};
        vecs[5] = '{n: 5,  gap: 2, exp_writes: 5,  bad_sum: 1'b1};

        // Reset state and idle state after release.
        repeat (3) step();
        @(negedge clk);
        checkOutput("reset_outputs", 64'({bus.byte_ready, bus.mem_wr_en, bus.mem_wr_addr,
                    bus.mem_wr_data, core_hold, busy, done, err}), 64'd0);
        reset = 1'b0;
        step();
        @(negedge clk);
        checkOutput("idle_outputs", 64'({bus.byte_ready, bus.mem_wr_en, bus.mem_wr_addr,
                    bus.mem_wr_data, core_hold, busy, done, err}), 64'd0);
        step();

        // Basic program, back-to-back bytes, with literal expected words.
        w0 = wlog_data.size();
        run_load(2, 2, 0, 1'b1, 1'b0, 1'b0, "basic");
        if (wlog_data.size() >= w0 + 2) begin
            checkOutput("basic_word0", 64'(wlog_data[w0]),   64'h0050_0093);
            checkOutput("basic_word1", 64'(wlog_data[w0+1]), 64'h00A1_0113);
        end

        // Same stream with byte_valid toggling.
        run_load(2, 2, 1, 1'b1, 1'b0, 1'b0, "backpressure");

        // start pulsed mid-load must be ignored.
        run_load(2, 2, 0, 1'b1, 1'b0, 1'b1, "start_in_recv");

        // Zero-word load: done the cycle after start, idle the cycle after that.
        w0 = wlog_data.size();
        start_load(0);
        @(negedge clk);
        checkOutput("zero_done", 64'({done, busy}), 64'b11);
        @(negedge clk);
        checkOutput("zero_idle", 64'({done, busy, core_hold}), 64'b000);
        step();
        checkOutput("zero_no_write", 64'(wlog_data.size() - w0), 64'd0);

        // Reset after 6 of 8 bytes: only word 0 written, then reload from 0.
        w0 = wlog_data.size();
        start_load(2);
        for (int i = 0; i < 6; i++) send_byte(basic_bytes[i], 0, ok);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        step();
        @(negedge clk);
        checkOutput("reset_mid_outputs", 64'({bus.byte_ready, bus.mem_wr_en, bus.mem_wr_addr,
                    bus.mem_wr_data, core_hold, busy, done, err}), 64'd0);
        reset = 1'b0;
        step();
        step();
        checkOutput("reset_mid_writes", 64'(wlog_data.size() - w0), 64'd1);
        if (wlog_data.size() > w0) begin
            checkOutput("reset_mid_addr0", 64'(wlog_addr[w0]), 64'd0);
            checkOutput("reset_mid_word0", 64'(wlog_data[w0]), 64'h0050_0093);
        end
        run_load(2, 2, 0, 1'b1, 1'b0, 1'b0, "reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: err sets, stays set, and clears on the next start.
        run_load(2, 2, 0, 1'b1, 1'b1, 1'b0, "bad_sum");
        repeat (3) step();
        checkOutput("err_sticky", 64'(err), 64'd1);
        start_load(0);
        @(negedge clk);
        checkOutput("err_cleared", 64'(err), 64'd0);
        step();
        step();
`endif

        // Randomized loads from the vector table.
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
